// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared types and pricing/coin helpers for vending_machine_multi
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    REFUND
  } state_t;

  typedef enum logic [2:0] {
    COIN_NONE = 3'd0,
    COIN_1    = 3'd1,
    COIN_2    = 3'd2,
    COIN_5    = 3'd3,
    COIN_10   = 3'd4,
    COIN_20   = 3'd5,
    COIN_BAD6 = 3'd6,
    COIN_BAD7 = 3'd7
  } coin_t;

  function automatic logic [7:0] coin_value(input logic [2:0] code);
    case (coin_t'(code))
      COIN_1:  return 8'd1;
      COIN_2:  return 8'd2;
      COIN_5:  return 8'd5;
      COIN_10: return 8'd10;
      COIN_20: return 8'd20;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic coin_valid(input logic [2:0] code);
    return (code >= 3'(COIN_1)) && (code <= 3'(COIN_20));
  endfunction

  function automatic logic [7:0] item_price(input logic [3:0] idx);
    return 8'd5 * ({4'd0, idx} + 8'd1);
  endfunction

endpackage

// File: rtl/vm_stock.sv
// rtl/vm_stock.sv - per-item stock counter bank with restock and single decrement
module vm_stock #(
  parameter int N_ITEMS    = 4,
  parameter int STOCK_INIT = 3,
  parameter int STOCK_W    = 4,
  localparam int ITEM_W    = $clog2(N_ITEMS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restock,
  input  logic              dec_en,
  input  logic [ITEM_W-1:0] dec_idx,
  input  logic [ITEM_W-1:0] rd_idx,
  output logic              rd_empty
);

  logic [STOCK_W-1:0] count [N_ITEMS];

  always_ff @(posedge clk) begin
    if (!reset_n || restock) begin
      for (int i = 0; i < N_ITEMS; i++) count[i] <= STOCK_W'(STOCK_INIT);
    end else if (dec_en && count[dec_idx] != '0) begin
      count[dec_idx] <= count[dec_idx] - STOCK_W'(1);
    end
  end

  // Indices past N_ITEMS (non power-of-two banks) read as empty so they can never be sold.
  assign rd_empty = (32'(rd_idx) >= N_ITEMS) || (count[rd_idx] == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - multi-item vending FSM with credit, stock and refund
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int MAX_CREDIT = 40,
  parameter int STOCK_INIT = 3,
  parameter int STOCK_W    = 4,
  localparam int ITEM_W    = $clog2(N_ITEMS),
  localparam int CREDIT_W  = $clog2(MAX_CREDIT + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ITEM_W-1:0]   item_in,
  input  logic [2:0]          money,
  input  logic                done_money,
  input  logic                cancel,
  input  logic                continue_buy,
  input  logic                restock,
  output logic                done,
  output logic [N_ITEMS-1:0]  item_out,
  output logic [CREDIT_W-1:0] change,
  output logic                sold_out,
  output logic                coin_reject
);

  state_t              state;
  logic [CREDIT_W-1:0] credit;
  logic [ITEM_W-1:0]   sel;
  logic                keep_credit;

  logic                rd_empty;
  logic                stock_restock;
  logic                coin_present;
  logic                coin_fits;
  logic [31:0]         coin_sum;
  logic [31:0]         price;
  logic [CREDIT_W-1:0] credit_acc;
  logic [CREDIT_W-1:0] remain;
  logic                enough;
  logic [N_ITEMS-1:0]  sel_onehot;

  always_comb begin
    coin_present  = (money != 3'(COIN_NONE));
    coin_sum      = 32'(credit) + 32'(coin_value(money));
    coin_fits     = coin_valid(money) && (coin_sum <= 32'(MAX_CREDIT));
    credit_acc    = coin_fits ? CREDIT_W'(coin_sum) : credit;
    price         = 32'(item_price(4'(sel)));
    // Purchase decision includes a coin accepted in the same cycle as done_money.
    enough        = (32'(credit_acc) >= price);
    remain        = CREDIT_W'(32'(credit) - price);
    sel_onehot    = {{(N_ITEMS-1){1'b0}}, 1'b1} << sel;
    stock_restock = (state == IDLE) && restock && !start && !(cancel && credit != '0);
  end

  vm_stock #(
    .N_ITEMS   (N_ITEMS),
    .STOCK_INIT(STOCK_INIT),
    .STOCK_W   (STOCK_W)
  ) u_stock (
    .clk     (clk),
    .reset_n (reset_n),
    .restock (stock_restock),
    .dec_en  (state == VEND),
    .dec_idx (sel),
    .rd_idx  (item_in),
    .rd_empty(rd_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      credit      <= '0;
      sel         <= '0;
      keep_credit <= 1'b0;
      done        <= 1'b0;
      item_out    <= '0;
      change      <= '0;
      sold_out    <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      done        <= 1'b0;
      item_out    <= '0;
      change      <= '0;
      sold_out    <= 1'b0;
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          coin_reject <= coin_present;
          if (start) begin
            if (rd_empty) begin
              sold_out <= 1'b1;
            end else begin
              sel   <= item_in;
              state <= COLLECT;
            end
          end else if (cancel && credit != '0) begin
            state <= REFUND;
          end
        end
        COLLECT: begin
          if (cancel) begin
            coin_reject <= coin_present;
            state       <= REFUND;
          end else begin
            coin_reject <= coin_present && !coin_fits;
            credit      <= credit_acc;
            if (done_money && enough) begin
              keep_credit <= continue_buy;
              state       <= VEND;
            end
          end
        end
        VEND: begin
          coin_reject <= coin_present;
          done        <= 1'b1;
          item_out    <= sel_onehot;
          if (keep_credit) begin
            credit <= remain;
          end else begin
            change <= remain;
            credit <= '0;
          end
          state <= IDLE;
        end
        REFUND: begin
          coin_reject <= coin_present;
          done        <= 1'b1;
          change      <= credit;
          credit      <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// tb/tb_vending_machine_multi.sv - directed self-checking bench for vending_machine_multi
module tb_vending_machine_multi;
  import vm_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] item_in = '0;
  logic [2:0] money = '0;
  logic       done_money = 1'b0;
  logic       cancel = 1'b0;
  logic       continue_buy = 1'b0;
  logic       restock = 1'b0;
  logic       done;
  logic [3:0] item_out;
  logic [5:0] change;
  logic       sold_out;
  logic       coin_reject;

  int checks = 0;
  int errors = 0;

  vending_machine_multi dut (
    .clk(clk), .reset_n(reset_n), .start(start), .item_in(item_in), .money(money),
    .done_money(done_money), .cancel(cancel), .continue_buy(continue_buy), .restock(restock),
    .done(done), .item_out(item_out), .change(change), .sold_out(sold_out),
    .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({done, item_out, change, sold_out, coin_reject} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {done, item_out, change, sold_out, coin_reject});
    end
    checks++;
    if (dut.credit !== 6'd0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state got credit=%0d state=%0d want 0/IDLE", dut.credit, dut.state);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.u_stock.count[i] !== 4'd3) begin
        errors++;
        $display("FAIL reset_stock%0d got %0d want 3", i, dut.u_stock.count[i]);
      end
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_vend_item1();
    start = 1'b1; item_in = 2'd1; tick(); start = 1'b0;
    money = 3'd4; tick();
    money = 3'd3; tick(); money = 3'd0;
    done_money = 1'b1; tick(); done_money = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL vend1_early got done=%b want 0", done);
    end
    tick();
    checks++;
    if ({done, item_out, change} !== {1'b1, 4'b0010, 6'd5}) begin
      errors++;
      $display("FAIL vend1_out got done=%b item=%b change=%0d want 1/0010/5", done, item_out, change);
    end
    checks++;
    if (dut.u_stock.count[1] !== 4'd2) begin
      errors++;
      $display("FAIL vend1_stock got %0d want 2", dut.u_stock.count[1]);
    end
    tick();
    checks++;
    if ({done, item_out, change} !== 11'd0) begin
      errors++;
      $display("FAIL vend1_pulse_end got %b want 0", {done, item_out, change});
    end
  endtask

  task automatic test_cancel_item2();
    start = 1'b1; item_in = 2'd2; tick(); start = 1'b0;
    money = 3'd3; tick(); money = 3'd0;
    cancel = 1'b1; tick(); cancel = 1'b0;
    tick();
    checks++;
    if ({done, item_out, change} !== {1'b1, 4'b0000, 6'd5}) begin
      errors++;
      $display("FAIL cancel2_out got done=%b item=%b change=%0d want 1/0000/5", done, item_out, change);
    end
    checks++;
    if (dut.u_stock.count[2] !== 4'd3) begin
      errors++;
      $display("FAIL cancel2_stock got %0d want 3", dut.u_stock.count[2]);
    end
    tick();
  endtask

  task automatic test_sold_out();
    for (int n = 0; n < 3; n++) begin
      start = 1'b1; item_in = 2'd0; tick(); start = 1'b0;
      money = 3'd3; tick(); money = 3'd0;
      done_money = 1'b1; tick(); done_money = 1'b0;
      tick();
      checks++;
      if ({done, item_out, change} !== {1'b1, 4'b0001, 6'd0}) begin
        errors++;
        $display("FAIL buy0_%0d got done=%b item=%b change=%0d want 1/0001/0", n, done, item_out, change);
      end
      tick();
    end
    start = 1'b1; item_in = 2'd0; tick(); start = 1'b0;
    checks++;
    if (sold_out !== 1'b1 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL sold_out_pulse got sold_out=%b state=%0d want 1/IDLE", sold_out, dut.state);
    end
    tick();
    checks++;
    if (sold_out !== 1'b0) begin
      errors++;
      $display("FAIL sold_out_clear got %b want 0", sold_out);
    end
    restock = 1'b1; tick(); restock = 1'b0;
    start = 1'b1; item_in = 2'd0; tick(); start = 1'b0;
    checks++;
    if (dut.state !== COLLECT || sold_out !== 1'b0) begin
      errors++;
      $display("FAIL restock_start got state=%0d sold_out=%b want COLLECT/0", dut.state, sold_out);
    end
    cancel = 1'b1; tick(); cancel = 1'b0;
    tick();
    checks++;
    if ({done, item_out, change} !== {1'b1, 4'b0000, 6'd0}) begin
      errors++;
      $display("FAIL cancel_zero got done=%b item=%b change=%0d want 1/0000/0", done, item_out, change);
    end
    tick();
  endtask

  task automatic test_coin_reject();
    start = 1'b1; item_in = 2'd3; tick(); start = 1'b0;
    money = 3'd5; tick();
    money = 3'd5; tick();
    checks++;
    if (coin_reject !== 1'b0 || dut.credit !== 6'd40) begin
      errors++;
      $display("FAIL fill40 got reject=%b credit=%0d want 0/40", coin_reject, dut.credit);
    end
    money = 3'd4; tick();
    checks++;
    if (coin_reject !== 1'b1 || dut.credit !== 6'd40) begin
      errors++;
      $display("FAIL saturate got reject=%b credit=%0d want 1/40", coin_reject, dut.credit);
    end
    money = 3'd7; tick();
    checks++;
    if (coin_reject !== 1'b1 || dut.credit !== 6'd40) begin
      errors++;
      $display("FAIL invalid_code got reject=%b credit=%0d want 1/40", coin_reject, dut.credit);
    end
    money = 3'd1; cancel = 1'b1; tick(); money = 3'd0; cancel = 1'b0;
    checks++;
    if (coin_reject !== 1'b1 || dut.credit !== 6'd40) begin
      errors++;
      $display("FAIL cancel_coin got reject=%b credit=%0d want 1/40", coin_reject, dut.credit);
    end
    tick();
    checks++;
    if ({done, item_out, change} !== {1'b1, 4'b0000, 6'd40}) begin
      errors++;
      $display("FAIL refund40 got done=%b item=%b change=%0d want 1/0000/40", done, item_out, change);
    end
    tick();
  endtask

  task automatic test_continue_buy();
    start = 1'b1; item_in = 2'd0; tick(); start = 1'b0;
    money = 3'd5; tick(); money = 3'd0;
    done_money = 1'b1; continue_buy = 1'b1; tick(); done_money = 1'b0; continue_buy = 1'b0;
    tick();
    checks++;
    if ({done, item_out, change} !== {1'b1, 4'b0001, 6'd0} || dut.credit !== 6'd15) begin
      errors++;
      $display("FAIL keep_credit got done=%b item=%b change=%0d credit=%0d want 1/0001/0/15",
               done, item_out, change, dut.credit);
    end
    start = 1'b1; item_in = 2'd1; tick(); start = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_gap got %b want 0", done);
    end
    done_money = 1'b1; tick(); done_money = 1'b0;
    tick();
    checks++;
    if ({done, item_out, change} !== {1'b1, 4'b0010, 6'd5} || dut.credit !== 6'd0) begin
      errors++;
      $display("FAIL carry_buy got done=%b item=%b change=%0d credit=%0d want 1/0010/5/0",
               done, item_out, change, dut.credit);
    end
    tick();
  endtask

  task automatic test_done_money_boundary();
    money = 3'd1; tick(); money = 3'd0;
    checks++;
    if (coin_reject !== 1'b1 || dut.credit !== 6'd0) begin
      errors++;
      $display("FAIL idle_coin got reject=%b credit=%0d want 1/0", coin_reject, dut.credit);
    end
    start = 1'b1; item_in = 2'd2; tick(); start = 1'b0;
    money = 3'd4; tick(); money = 3'd0;
    done_money = 1'b1; tick();
    checks++;
    if (dut.state !== COLLECT || done !== 1'b0) begin
      errors++;
      $display("FAIL short_credit got state=%0d done=%b want COLLECT/0", dut.state, done);
    end
    money = 3'd3; tick(); money = 3'd0; done_money = 1'b0;
    tick();
    checks++;
    if ({done, item_out, change} !== {1'b1, 4'b0100, 6'd0}) begin
      errors++;
      $display("FAIL coin_with_done got done=%b item=%b change=%0d want 1/0100/0", done, item_out, change);
    end
    checks++;
    if (dut.u_stock.count[2] !== 4'd2) begin
      errors++;
      $display("FAIL stock2_dec got %0d want 2", dut.u_stock.count[2]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; item_in = 2'd2; tick(); start = 1'b0;
    money = 3'd4; tick();
    money = 3'd3; tick(); money = 3'd0;
    checks++;
    if (dut.credit !== 6'd15) begin
      errors++;
      $display("FAIL mid_credit got %0d want 15", dut.credit);
    end
    reset_n = 1'b0; tick();
    checks++;
    if ({done, item_out, change, sold_out, coin_reject} !== 13'd0 || dut.credit !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset got outs=%b credit=%0d want 0/0",
               {done, item_out, change, sold_out, coin_reject}, dut.credit);
    end
    checks++;
    if (dut.u_stock.count[0] !== 4'd3 || dut.u_stock.count[1] !== 4'd3 || dut.u_stock.count[2] !== 4'd3) begin
      errors++;
      $display("FAIL mid_stock got %0d/%0d/%0d want 3/3/3",
               dut.u_stock.count[0], dut.u_stock.count[1], dut.u_stock.count[2]);
    end
    reset_n = 1'b1; tick(); tick();
    checks++;
    if (done !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL after_reset got done=%b state=%0d want 0/IDLE", done, dut.state);
    end
  endtask

  initial begin
    test_reset();
    test_vend_item1();
    test_cancel_item2();
    test_sold_out();
    test_coin_reject();
    test_continue_buy();
    test_done_money_boundary();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
# vending_machine_multi

Parametrised successor to the team's single-product vending controller. It supports `N_ITEMS` products with per-item stock counters, a coded coin acceptor with credit saturation, and sold-out and coin-reject signalling. Credit can carry over between purchases through `continue_buy`. It sits between the keypad/coin-acceptor front end and the dispenser/change-hopper drivers.

## Interface
- `N_ITEMS`, 4: number of products, valid range 2..8.
- `MAX_CREDIT`, 40: credit ceiling in currency units.
- `STOCK_INIT`, 3: units per item after reset or restock, at least 1.
- `STOCK_W`, 4: stock counter width; requires `STOCK_INIT < 2**STOCK_W`.
- Derived localparams:
  - `ITEM_W = $clog2(N_ITEMS)`
  - `CREDIT_W = $clog2(MAX_CREDIT+1)`
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a purchase of `item_in`; sampled in IDLE only.
- `item_in` in `ITEM_W`: product index.
- `money` in 3: coin code. 0 = none, 1 = 1, 2 = 2, 3 = 5, 4 = 10, 5 = 20; codes 6 and 7 are invalid.
- `done_money` in 1: customer finished inserting coins; sampled in COLLECT.
- `cancel` in 1: abort and refund; sampled in IDLE (only when credit > 0) and in COLLECT.
- `continue_buy` in 1: keep change as credit; sampled together with `done_money`.
- `restock` in 1: reload every stock counter to `STOCK_INIT`; honoured in IDLE only.
- `done` out 1: one-cycle pulse when a transaction completes (vend or refund).
- `item_out` out `N_ITEMS`: one-hot dispensed item, valid while `done` is high, else 0.
- `change` out `CREDIT_W`: change or refund amount, valid while `done` is high, else 0.
- `sold_out` out 1: one-cycle pulse when `start` selects an item with zero stock.
- `coin_reject` out 1: one-cycle pulse when a coin is not accepted.

## Operation
- Price of item i = 5·(i+1), given by a package function.
- IDLE:
  - `start` with stock[item_in] = 0: pulse `sold_out`, stay in IDLE, credit unchanged.
  - `start` with stock > 0: latch `sel = item_in`, go to COLLECT.
  - `cancel` with credit > 0: go to REFUND. Otherwise `restock` is applied if asserted.
  - Coins arriving in IDLE are rejected.
- COLLECT:
  - Priority is `cancel` > coin > `done_money`.
  - `cancel`: go to REFUND; any coin presented in the same cycle is rejected.
  - Coin of value v: accepted (credit += v) if credit + v ≤ `MAX_CREDIT`; otherwise `coin_reject` pulses and credit is unchanged. Invalid codes are always rejected.
  - `done_money`: the decision uses the credit *including* any coin accepted in the same cycle.
    - credit ≥ price: latch `continue_buy` and go to VEND.
    - Otherwise stay in COLLECT; no pulse.
- VEND (one cycle):
  - Outputs: `done` = 1 and `item_out` = one-hot(`sel`).
  - stock[sel] decrements by 1.
  - Without latched `continue_buy`: `change` = credit − price and credit is cleared.
  - With latched `continue_buy`: `change` = 0 and credit becomes credit − price.
  - Next state: IDLE.
- REFUND (one cycle): `done` = 1, `item_out` = 0, `change` = credit; credit is cleared; next state IDLE.
- All arithmetic is unsigned at `CREDIT_W`; overflow is impossible by construction.

## Timing
- All outputs are registered.
- Reset values:
  - `done`, `item_out`, `change`, `sold_out`, `coin_reject` = 0.
  - State = IDLE, credit = 0, `sel` = 0.
  - All stock counters = `STOCK_INIT`.
- Reset asserted mid-transaction discards credit without a refund pulse.
- Latencies:
  - `start` sampled at edge t: COLLECT from t+1.
  - `done_money` sampled at edge t: `done`/`item_out`/`change` high for exactly the cycle after edge t+1.
  - `sold_out` and `coin_reject` are high in the cycle following the sampling edge.
- At most one coin is accepted per cycle. Back-to-back coins on consecutive cycles are all processed.
- `done` is never asserted in two consecutive cycles.

## Structure
- Package `vm_pkg`:
  - `state_t` enum: IDLE, COLLECT, VEND, REFUND.
  - `coin_t` enum for the coin codes.
  - `coin_value()` and `item_price()` functions.
- Sub-module `vm_stock`:
  - Holds the `N_ITEMS` × `STOCK_W` counter bank.
  - Ports: `clk`, `reset_n`, `restock`, `dec_en`, `dec_idx`, `rd_idx`, `rd_empty`.
- Top level: FSM, credit register, output registers.

## Test plan
- Item 1: coins 10, 5, then `done_money` → `done` = 1, `item_out` = 0010, `change` = 5; stock[1] goes 3 → 2.
- Item 2: coin 5, then `cancel` → `done` = 1, `item_out` = 0000, `change` = 5; stock[2] unchanged.
- Three successful buys of item 0, then a fourth `start` on item 0 → `sold_out` pulse, state stays IDLE. `restock`, then `start` → enters COLLECT.
- Coins 20, 20, 10 → third coin gives a `coin_reject` pulse and credit stays 40. Coin code 7 → rejected. Coin with `cancel` in the same cycle → rejected, refund = prior credit.
- Item 0 with coin 20, `done_money` and `continue_buy` → `item_out` = 0001, `change` = 0. Then `start` on item 1 with immediate `done_money` → `item_out` = 0010, `change` = 5.
- `reset_n` low during COLLECT with credit 15 → all outputs 0, no `done` pulse, stock reloaded to 3, credit 0.
